// File: rtl/mbox_read_buf.sv
// ---------------------------------------------------------------------------
// mbox_read_buf
//   Show-ahead read buffer between the MBOX memory return path and the EDP.
//   The oldest buffered word is always presented on cacheDataRead and is
//   consumed when CON asserts CON_memRead. CON_flush discards everything.
//   Sticky error flags record underruns and (optionally) parity failures.
//
//   Optional feature macro: MBOX_READ_BUF_PARITY_EN
//     defined     - odd-parity check on every accepted word sets parityErr
//     not defined - MBOX_parity is ignored and parityErr is tied low
//
//   Bit numbering: the machine numbers a word [0:35] with bit 0 as the MSB.
//   Here the vectors are declared [35:0], so machine bit 0 is vector bit 35.
// ---------------------------------------------------------------------------
module mbox_read_buf #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             eboxClk,
    input  logic             eboxReset_n,
    input  logic [35:0]      MBOX_data,
    input  logic             MBOX_parity,
    input  logic             MBOX_valid,
    output logic             MBOX_ready,
    input  logic             CON_memRead,
    input  logic             CON_flush,
    input  logic             CON_errClr,
    output logic [35:0]      cacheDataRead,
    output logic             cacheDataValid,
    output logic [CNT_W-1:0] bufCount,
    output logic             underrunErr,
    output logic             parityErr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Storage is deliberately not reset; emptiness is tracked by count_r.
    logic [35:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             underrun_r;
    logic             parity_r;

    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic             underrun_ev_s;
    logic             parity_ev_s;

`ifdef MBOX_READ_BUF_PARITY_EN
    // Odd parity: an even number of ones across data plus parity bit is an error.
    function automatic logic parity_bad(input logic [35:0] data, input logic par);
        parity_bad = ~(^{data, par});
    endfunction
`else
    // Parity input has no function in this build.
    logic unused_parity_s;
    assign unused_parity_s = MBOX_parity;
`endif

    // Handshake decode; flush blocks both the push and the pop of its cycle.
    always_comb begin
        empty_s       = (count_r == {CNT_W{1'b0}});
        full_s        = (count_r == CNT_FULL);
        MBOX_ready    = ~full_s & ~CON_flush;
        push_s        = MBOX_valid & MBOX_ready;
        pop_s         = CON_memRead & ~empty_s & ~CON_flush;
        underrun_ev_s = CON_memRead & empty_s;
`ifdef MBOX_READ_BUF_PARITY_EN
        parity_ev_s   = push_s & parity_bad(MBOX_data, MBOX_parity);
`else
        parity_ev_s   = 1'b0;
`endif
    end

    // Word storage: write the accepted word at the tail slot.
    always_ff @(posedge eboxClk) begin
        if (push_s) begin
            mem_r[tail_r] <= MBOX_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (CON_flush) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags; a new error event beats a same-cycle clear.
    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            underrun_r <= 1'b0;
            parity_r   <= 1'b0;
        end else begin
            if (underrun_ev_s) begin
                underrun_r <= 1'b1;
            end else if (CON_errClr) begin
                underrun_r <= 1'b0;
            end else begin
                underrun_r <= underrun_r;
            end
            if (parity_ev_s) begin
                parity_r <= 1'b1;
            end else if (CON_errClr) begin
                parity_r <= 1'b0;
            end else begin
                parity_r <= parity_r;
            end
        end
    end

    // Output presentation straight from registered state; zero word when empty.
    always_comb begin
        cacheDataValid = ~empty_s;
        if (empty_s) begin
            cacheDataRead = 36'h0_0000_0000;
        end else begin
            cacheDataRead = mem_r[head_r];
        end
        bufCount    = count_r;
        underrunErr = underrun_r;
        parityErr   = parity_r;
    end

endmodule

// File: tb/tb_mbox_read_buf.sv
// ---------------------------------------------------------------------------
// tb_mbox_read_buf
//   Directed bench for mbox_read_buf. A queue-based model tracks what the
//   buffer must hold; a compare process checks all outputs every falling edge,
//   and the stimulus sequence adds hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_mbox_read_buf;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic [35:0]      mbox_data;
    logic             mbox_parity;
    logic             mbox_valid;
    logic             mbox_ready;
    logic             mem_read;
    logic             flush;
    logic             err_clr;
    logic [35:0]      cache_data;
    logic             cache_valid;
    logic [CNT_W-1:0] buf_count;
    logic             underrun_err;
    logic             parity_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [35:0] q[$];
    logic        m_underrun;
    logic        m_parity;

    mbox_read_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .eboxClk       (clk),
        .eboxReset_n   (rst_n),
        .MBOX_data     (mbox_data),
        .MBOX_parity   (mbox_parity),
        .MBOX_valid    (mbox_valid),
        .MBOX_ready    (mbox_ready),
        .CON_memRead   (mem_read),
        .CON_flush     (flush),
        .CON_errClr    (err_clr),
        .cacheDataRead (cache_data),
        .cacheDataValid(cache_valid),
        .bufCount      (buf_count),
        .underrunErr   (underrun_err),
        .parityErr     (parity_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: FIFO of words plus two sticky flags.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_underrun = 1'b0;
            m_parity   = 1'b0;
        end else begin
            int  sz;
            bit  acc;
            bit  perr;
            sz   = q.size();
            acc  = mbox_valid && !flush && (sz < DEPTH);
`ifdef MBOX_READ_BUF_PARITY_EN
            perr = acc && (($countones({mbox_data, mbox_parity}) % 2) == 0);
`else
            perr = 1'b0;
`endif
            if (mem_read && sz == 0) m_underrun = 1'b1;
            else if (err_clr)        m_underrun = 1'b0;
            if (perr)                m_parity = 1'b1;
            else if (err_clr)        m_parity = 1'b0;
            if (flush) begin
                q.delete();
            end else begin
                if (mem_read && sz > 0) void'(q.pop_front());
                if (acc) q.push_back(mbox_data);
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("count",    36'(buf_count),    36'(q.size()));
            check("valid",    36'(cache_valid),  36'(q.size() != 0));
            check("data",     cache_data,        (q.size() != 0) ? q[0] : 36'h0);
            check("ready",    36'(mbox_ready),   36'((q.size() != DEPTH) && !flush));
            check("underrun", 36'(underrun_err), 36'(m_underrun));
            check("parity",   36'(parity_err),   36'(m_parity));
        end
    end

    // Apply one cycle of inputs, return 2 time units after the edge with inputs idle.
    task automatic drive(input logic v, input logic [35:0] d, input logic p,
                         input logic rd, input logic fl, input logic clr);
        mbox_valid  = v;
        mbox_data   = d;
        mbox_parity = p;
        mem_read    = rd;
        flush       = fl;
        err_clr     = clr;
        @(posedge clk);
        #2;
        mbox_valid  = 1'b0;
        mbox_data   = 36'h0;
        mbox_parity = 1'b0;
        mem_read    = 1'b0;
        flush       = 1'b0;
        err_clr     = 1'b0;
    endtask

    task automatic push(input logic [35:0] d);
        drive(1'b1, d, ^d ^ 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        drive(1'b0, 36'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [35:0] exp_seq [4];
        rst_n       = 1'b0;
        mbox_valid  = 1'b0;
        mbox_data   = 36'h0;
        mbox_parity = 1'b0;
        mem_read    = 1'b0;
        flush       = 1'b0;
        err_clr     = 1'b0;
        #11;
        check("rst_count", 36'(buf_count),   36'd0);
        check("rst_valid", 36'(cache_valid), 36'd0);
        check("rst_data",  cache_data,       36'h0);
        check("rst_ready", 36'(mbox_ready),  36'd1);
        #1 rst_n = 1'b1;

        // 1: single push, one-cycle latency
        push(36'h123456789);
        check("t1_data",  cache_data,        36'h123456789);
        check("t1_valid", 36'(cache_valid),  36'd1);
        check("t1_count", 36'(buf_count),    36'd1);

        // 2: fill, blocked fifth word, wrap ordering
        push(36'hAAAAAAAAA);
        push(36'h555555555);
        push(36'h0F0F0F0F0);
        check("t2_full_count", 36'(buf_count),  36'd4);
        check("t2_full_ready", 36'(mbox_ready), 36'd0);
        push(36'h777777777);
        check("t2_held_count", 36'(buf_count),  36'd4);
        drive(1'b1, 36'h777777777, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t2_pop_count", 36'(buf_count), 36'd3);
        check("t2_pop_head",  cache_data,     36'hAAAAAAAAA);
        push(36'h777777777);
        check("t2_refill_count", 36'(buf_count), 36'd4);
        exp_seq[0] = 36'hAAAAAAAAA;
        exp_seq[1] = 36'h555555555;
        exp_seq[2] = 36'h0F0F0F0F0;
        exp_seq[3] = 36'h777777777;
        for (int i = 0; i < 4; i++) begin
            check("t2_order", cache_data, exp_seq[i]);
            pop();
        end
        check("t2_empty_valid", 36'(cache_valid), 36'd0);
        check("t2_empty_data",  cache_data,       36'h0);

        // 3: simultaneous push and pop at count 2
        push(36'h111111111);
        push(36'h222222222);
        drive(1'b1, 36'h987654321, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_count", 36'(buf_count), 36'd2);
        check("t3_head",  cache_data,     36'h222222222);
        pop();
        check("t3_next", cache_data, 36'h987654321);
        pop();

        // 4: underrun and clear
        pop();
        check("t4_underrun", 36'(underrun_err), 36'd1);
        check("t4_count",    36'(buf_count),    36'd0);
        drive(1'b0, 36'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t4_event_wins", 36'(underrun_err), 36'd1);
        drive(1'b0, 36'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_cleared", 36'(underrun_err), 36'd0);

        // 5: flush with push and pop in the same cycle
        push(36'h300000003);
        push(36'h300000004);
        push(36'h300000005);
        drive(1'b1, 36'hDEADBEEF1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t5_count", 36'(buf_count),   36'd0);
        check("t5_valid", 36'(cache_valid), 36'd0);
        check("t5_data",  cache_data,       36'h0);
        push(36'h0CAFE0001);
        check("t5_after", cache_data, 36'h0CAFE0001);
        pop();

        // 6: parity behaviour
        drive(1'b0, 36'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 36'h0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef MBOX_READ_BUF_PARITY_EN
        check("t6_bad_parity", 36'(parity_err), 36'd1);
        drive(1'b0, 36'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 36'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_good_parity", 36'(parity_err), 36'd0);
`else
        check("t6_parity_off", 36'(parity_err), 36'd0);
        drive(1'b1, 36'h0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
        check("t6_stored", cache_data, 36'h0);
        check("t6_count",  36'(buf_count), 36'd2);

        // Async reset mid-stream with an active underrun flag
        pop();
        pop();
        pop();
        push(36'h400000001);
        push(36'h400000002);
        #1 rst_n = 1'b0;
        #1;
        check("ar_count",    36'(buf_count),    36'd0);
        check("ar_valid",    36'(cache_valid),  36'd0);
        check("ar_data",     cache_data,        36'h0);
        check("ar_ready",    36'(mbox_ready),   36'd1);
        check("ar_underrun", 36'(underrun_err), 36'd0);
        check("ar_parity",   36'(parity_err),   36'd0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        push(36'h500000005);
        check("post_rst_data", cache_data, 36'h500000005);
        check("post_rst_count", 36'(buf_count), 36'd1);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
